tube_scheduler: RTL and testbench

- Sequences the obstacle datapath of the Flappy Bird game: owns the N tube slots (right-edge x, gap height h), scrolls them once per video frame, and recycles off-screen slots with new pseudo-random heights.
- Sits between rgb_timing (vs_in) and game_ctrl/display.
- game_ctrl keeps bird physics and collision, and drives run/clear.

---
 rtl/flappy_pkg.sv | 18 +
 rtl/tube_scheduler_lfsr16.sv | 21 ++
 rtl/tube_scheduler.sv | 170 +++++++++++++++++
 tb/tb_tube_scheduler.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// Shared constants and types for the Flappy Bird obstacle datapath.
// Holds screen geometry, bird column, LFSR taps and the scheduler state enum.
package flappy_pkg;

    localparam int H_ACTIVE = 640;
    localparam int TUBE_W   = 40;
    localparam int BIRD_X   = 160;

    // Galois taps for x^16 + x^14 + x^13 + x^11 + 1, shifting right
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        INIT,
        READY,
        SCROLL
    } tube_state_t;

endpackage

// File: rtl/tube_scheduler_lfsr16.sv
// Free-running 16-bit Galois LFSR used to draw tube gap heights.
// Ports: clk, rst_n (async, active-low), q = current LFSR state.
module lfsr16
    import flappy_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= SEED;
        end else begin
            q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/tube_scheduler.sv
// Tube slot owner: scrolls N_TUBE slots once per frame, recycles off-screen slots.
// Ports: clk, rst_n, vs_in, run, clear in; tube_x/tube_h packed 12b slots, busy, frame_done, score_pulse out.
module tube_scheduler #(
    parameter int          N_TUBE    = 5,
    parameter int          H_ACTIVE  = flappy_pkg::H_ACTIVE,
    parameter int          TUBE_W    = flappy_pkg::TUBE_W,
    parameter int          SPACING   = 160,
    parameter int          SPEED     = 2,
    parameter int          BIRD_X    = flappy_pkg::BIRD_X,
    parameter int          H_MIN     = 80,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  vs_in,
    input  logic                  run,
    input  logic                  clear,
    output logic [12*N_TUBE-1:0]  tube_x,
    output logic [12*N_TUBE-1:0]  tube_h,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  score_pulse
);
    import flappy_pkg::*;

    localparam int IW = (N_TUBE > 1) ? $clog2(N_TUBE) : 1;

    localparam logic [11:0] SPEED_12  = 12'(SPEED);
    localparam logic [11:0] BIRD_X_12 = 12'(BIRD_X);
    localparam logic [11:0] H_MIN_12  = 12'(H_MIN);
    localparam logic [11:0] WRAP_12   = 12'(N_TUBE * SPACING);
    localparam logic [IW-1:0] LAST    = IW'(N_TUBE - 1);

    if ((N_TUBE - 1) * SPACING + H_ACTIVE + TUBE_W >= 4096) begin : g_bad_xmax
        $error("tube x range does not fit in 12 bits");
    end
    if (N_TUBE * SPACING < H_ACTIVE + TUBE_W) begin : g_bad_wrap
        $error("tube ring shorter than visible width plus tube");
    end
    if (SPEED >= SPACING) begin : g_bad_speed
        $error("SPEED must be below SPACING");
    end
    if (LFSR_SEED == 16'h0000) begin : g_bad_seed
        $error("LFSR seed must be nonzero");
    end

    function automatic logic [11:0] home_x(input int i);
        return 12'(H_ACTIVE + TUBE_W + i * SPACING);
    endfunction

    tube_state_t   state;
    logic [IW-1:0] idx;
    logic [11:0]   x_r [N_TUBE];
    logic [11:0]   h_r [N_TUBE];

    logic        vs_q1;
    logic        vs_q2;
    logic        vs_q3;
    logic        tick;
    logic [15:0] lfsr_q;
    logic [11:0] draw;
    logic [11:0] cur_x;
    logic [11:0] dec_x;
    logic        last_slot;
    logic        unused_lfsr_hi;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (lfsr_q)
    );

    assign unused_lfsr_hi = ^lfsr_q[15:8];

    // Frame tick is the rising edge of the second synchroniser stage
    assign tick      = vs_q2 & ~vs_q3;
    assign draw      = H_MIN_12 + {4'h0, lfsr_q[7:0]};
    assign cur_x     = x_r[idx];
    assign dec_x     = cur_x - SPEED_12;
    assign last_slot = (idx == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q1 <= 1'b0;
            vs_q2 <= 1'b0;
            vs_q3 <= 1'b0;
        end else begin
            vs_q1 <= vs_in;
            vs_q2 <= vs_q1;
            vs_q3 <= vs_q2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= INIT;
            idx         <= '0;
            busy        <= 1'b1;
            frame_done  <= 1'b0;
            score_pulse <= 1'b0;
            for (int i = 0; i < N_TUBE; i++) begin
                x_r[i] <= home_x(i);
                h_r[i] <= H_MIN_12;
            end
        end else begin
            frame_done  <= 1'b0;
            score_pulse <= 1'b0;
            if (clear) begin
                // Aborts any pass in flight; no frame_done for it
                state <= INIT;
                idx   <= '0;
                busy  <= 1'b1;
            end else begin
                unique case (state)
                    INIT: begin
                        x_r[idx] <= home_x(int'(idx));
                        h_r[idx] <= draw;
                        if (last_slot) begin
                            state <= READY;
                            idx   <= '0;
                            busy  <= 1'b0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    READY: begin
                        if (tick && run) begin
                            state <= SCROLL;
                            idx   <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    SCROLL: begin
                        if (cur_x <= SPEED_12) begin
                            // Slot left the screen: move it behind the last tube
                            x_r[idx] <= dec_x + WRAP_12;
                            h_r[idx] <= draw;
                        end else begin
                            x_r[idx] <= dec_x;
                            if (cur_x > BIRD_X_12 && dec_x <= BIRD_X_12) begin
                                score_pulse <= 1'b1;
                            end
                        end
                        if (last_slot) begin
                            frame_done <= 1'b1;
                            state      <= READY;
                            idx        <= '0;
                            busy       <= 1'b0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    default: begin
                        state <= INIT;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                endcase
            end
        end
    end

    for (genvar g = 0; g < N_TUBE; g++) begin : g_pack
        assign tube_x[12*g +: 12] = x_r[g];
        assign tube_h[12*g +: 12] = h_r[g];
    end

endmodule

// File: tb/tb_tube_scheduler.sv
// Self-checking bench for tube_scheduler.
// Frame-level reference model plus a cycle-indexed LFSR history for height draws.
module tb_tube_scheduler;

    localparam int NT = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            vs_in;
    logic            run;
    logic            clear;
    logic [12*NT-1:0] tube_x;
    logic [12*NT-1:0] tube_h;
    logic            busy;
    logic            frame_done;
    logic            score_pulse;

    tube_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vs_in       (vs_in),
        .run         (run),
        .clear       (clear),
        .tube_x      (tube_x),
        .tube_h      (tube_h),
        .busy        (busy),
        .frame_done  (frame_done),
        .score_pulse (score_pulse)
    );

    always #5 clk = ~clk;

    // hist[c] is the LFSR value during cycle c (c posedges after release)
    logic [15:0] hist [0:32767];
    int cyc;

    function automatic logic [15:0] lstep(input logic [15:0] v);
        logic [15:0] s;
        s = v >> 1;
        if (v[0]) s = s ^ 16'hB400;
        return s;
    endfunction

    always @(posedge clk) begin
        if (rst_n === 1'b1 && cyc < 32767) begin
            hist[cyc + 1] = lstep(hist[cyc]);
            cyc = cyc + 1;
        end
    end

    int passed;
    int total;
    int mx [NT];
    int mh [NT];
    int got_fd, got_sc, exp_fd, exp_sc;

    typedef struct {
        bit run;
        int nfr;
        int x0;
        int x4;
        int fd;
        int sc;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int dx(input int i);
        return int'(tube_x[12*i +: 12]);
    endfunction

    function automatic int dh(input int i);
        return int'(tube_h[12*i +: 12]);
    endfunction

    task automatic reinit(input int base);
        for (int i = 0; i < NT; i++) begin
            mx[i] = 680 + 160 * i;
            mh[i] = 80 + int'(hist[base + i][7:0]);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < NT; i++) begin
            chk($sformatf("%s x%0d", tag, i), dx(i), mx[i]);
            chk($sformatf("%s h%0d", tag, i), dh(i), mh[i]);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        got_fd += int'(frame_done);
        got_sc += int'(score_pulse);
    endtask

    // One video frame: vs high 12 cycles, low 4+extra; model applied afterwards
    task automatic frame(input bit r, input int extra);
        int k;
        int old;
        k = cyc;
        run = r;
        vs_in = 1'b1;
        got_fd = 0;
        got_sc = 0;
        repeat (12) sample();
        vs_in = 1'b0;
        repeat (4 + extra) sample();
        exp_fd = 0;
        exp_sc = 0;
        if (r) begin
            exp_fd = 1;
            for (int i = 0; i < NT; i++) begin
                old = mx[i];
                if (old <= 2) begin
                    mx[i] = old - 2 + 800;
                    mh[i] = 80 + int'(hist[k + 3 + i][7:0]);
                end else begin
                    mx[i] = old - 2;
                    if (old > 160 && mx[i] <= 160) exp_sc++;
                end
            end
        end
    endtask

    initial begin
        int sfd, ssc, k, c;
        bit r;

        tbl[0] = '{1'b1, 1,   678, 1318, 1,   0};
        tbl[1] = '{1'b1, 258, 162, 802,  258, 0};
        tbl[2] = '{1'b1, 1,   160, 800,  1,   1};
        tbl[3] = '{1'b0, 10,  160, 800,  0,   0};
        tbl[4] = '{1'b1, 79,  2,   642,  79,  0};
        tbl[5] = '{1'b1, 1,   800, 640,  1,   1};

        passed = 0;
        total = 0;
        cyc = 0;
        hist[0] = 16'hACE1;
        rst_n = 1'b0;
        vs_in = 1'b0;
        run = 1'b0;
        clear = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        chk("reset busy", int'(busy), 1);
        chk("reset x0", dx(0), 680);
        chk("reset x4", dx(4), 1320);
        chk("reset h2", dh(2), 80);
        chk("reset frame_done", int'(frame_done), 0);
        chk("reset score", int'(score_pulse), 0);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk($sformatf("init busy c%0d", i), int'(busy), (i < 5) ? 1 : 0);
        end
        reinit(0);
        check_all("init");

        for (int r2 = 0; r2 < 6; r2++) begin
            sfd = 0;
            ssc = 0;
            for (int f = 0; f < tbl[r2].nfr; f++) begin
                frame(tbl[r2].run, 0);
                sfd += got_fd;
                ssc += got_sc;
                chk($sformatf("row%0d fd", r2), got_fd, exp_fd);
                chk($sformatf("row%0d score", r2), got_sc, exp_sc);
            end
            chk($sformatf("row%0d x0", r2), dx(0), tbl[r2].x0);
            chk($sformatf("row%0d x4", r2), dx(4), tbl[r2].x4);
            chk($sformatf("row%0d fd sum", r2), sfd, tbl[r2].fd);
            chk($sformatf("row%0d score sum", r2), ssc, tbl[r2].sc);
            check_all($sformatf("row%0d", r2));
        end
        chk("wrap spacing", dx(0) - dx(4), 160);

        // clear while slot 2 is about to update
        k = cyc;
        run = 1'b1;
        vs_in = 1'b1;
        got_fd = 0;
        got_sc = 0;
        repeat (5) sample();
        clear = 1'b1;
        sample();
        clear = 1'b0;
        chk("clear busy", int'(busy), 1);
        repeat (6) sample();
        chk("clear busy done", int'(busy), 0);
        vs_in = 1'b0;
        repeat (4) sample();
        chk("clear no fd", got_fd, 0);
        reinit(k + 6);
        check_all("clear");

        // tick landing inside INIT is dropped
        c = cyc;
        clear = 1'b1;
        vs_in = 1'b1;
        got_fd = 0;
        sample();
        clear = 1'b0;
        repeat (11) sample();
        vs_in = 1'b0;
        repeat (4) sample();
        chk("drop no fd", got_fd, 0);
        reinit(c + 1);
        check_all("drop");
        frame(1'b1, 0);
        chk("drop next x0", dx(0), 678);
        chk("drop next fd", got_fd, 1);
        check_all("drop next");

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                c = cyc;
                clear = 1'b1;
                @(negedge clk);
                clear = 1'b0;
                repeat (7) @(negedge clk);
                reinit(c + 1);
            end
            r = ($urandom_range(0, 3) != 0);
            frame(r, int'($urandom_range(0, 5)));
            chk("rnd fd", got_fd, exp_fd);
            chk("rnd score", got_sc, exp_sc);
            check_all("rnd");
        end

        // asynchronous reset in the middle of a pass
        run = 1'b1;
        vs_in = 1'b1;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async busy", int'(busy), 1);
        chk("async fd", int'(frame_done), 0);
        chk("async x0", dx(0), 680);
        chk("async x3", dx(3), 1160);
        chk("async h0", dh(0), 80);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
